// File: rtl/alu_pkg.sv
// Shared ALU-side types: datapath widths, op encoding and the operand bundle
// handed from the operand stage to the ALU.
package alu_pkg;

  localparam int unsigned DW   = 8;
  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = 3;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_ANDB  = 2'b01,
    OP_XOR   = 2'b10,
    OP_SHIFT = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [DW-1:0] in1;
    logic [DW-1:0] in2;
    alu_op_e       alu_op;
    logic          sub;
  } op_bundle_t;

endpackage

// File: rtl/operand_stage_reg_file.sv
// Architectural register file: NREG x DW, two combinational read ports with
// write-through bypass, one synchronous write port.
module reg_file #(
  parameter int unsigned DW   = 8,
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data
);

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Same-cycle write-back wins over the stored value on each port independently
  always_comb begin
    rs_data = regs[rs_addr];
    rt_data = regs[rt_addr];
    if (wr_en && (wr_addr == rs_addr)) rs_data = wr_data;
    if (wr_en && (wr_addr == rt_addr)) rt_data = wr_data;
  end

endmodule

// File: rtl/operand_stage.sv
// Issue/operand stage ahead of the 8-bit ALU: register-file read with bypass,
// operand muxing and a single valid/stall/flush pipeline register.
module operand_stage
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  input  logic          imm_sel,
  input  logic [DW-1:0] imm,
  input  logic [1:0]    op_in,
  input  logic          sub_in,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          stall,
  input  logic          flush,
  output logic          out_valid,
  output logic [DW-1:0] in1,
  output logic [DW-1:0] in2,
  output logic [1:0]    alu_op,
  output logic          sub
);

  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  op_bundle_t    next_bundle;
  op_bundle_t    bundle_q;
  logic          valid_q;

  reg_file #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  assign in_ready = !stall;

  // sub is only meaningful for add; clear it for every other op
  always_comb begin
    next_bundle        = '0;
    next_bundle.in1    = rs_data;
    next_bundle.in2    = imm_sel ? imm : rt_data;
    next_bundle.alu_op = alu_op_e'(op_in);
    next_bundle.sub    = sub_in && (op_in == 2'b00);
  end

  // Priority: reset > flush > stall > capture/bubble
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else if (!stall) begin
      valid_q <= in_valid;
      if (in_valid) begin
        bundle_q <= next_bundle;
      end
    end
  end

  assign out_valid = valid_q;
  assign in1       = bundle_q.in1;
  assign in2       = bundle_q.in2;
  assign alu_op    = 2'(bundle_q.alu_op);
  assign sub       = bundle_q.sub;

endmodule

// File: tb/tb_operand_stage.sv
// Directed, table-driven bench for operand_stage with hand-computed expectations.
module tb_operand_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] rs_addr;
  logic [2:0] rt_addr;
  logic       imm_sel;
  logic [7:0] imm;
  logic [1:0] op_in;
  logic       sub_in;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       stall;
  logic       flush;
  logic       out_valid;
  logic [7:0] in1;
  logic [7:0] in2;
  logic [1:0] alu_op;
  logic       sub;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  operand_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .imm_sel   (imm_sel),
    .imm       (imm),
    .op_in     (op_in),
    .sub_in    (sub_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .in1       (in1),
    .in2       (in2),
    .alu_op    (alu_op),
    .sub       (sub)
  );

  typedef struct {
    logic       rst;
    logic       wen;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       iv;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       isel;
    logic [7:0] im;
    logic [1:0] op;
    logic       si;
    logic       st;
    logic       fl;
    logic       e_rdy;
    logic       e_ov;
    logic [7:0] e_in1;
    logic [7:0] e_in2;
    logic [1:0] e_op;
    logic       e_sub;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic wen, logic [2:0] wa, logic [7:0] wd,
                              logic iv, logic [2:0] rs, logic [2:0] rt, logic isel,
                              logic [7:0] im, logic [1:0] op, logic si, logic st, logic fl,
                              logic e_rdy, logic e_ov, logic [7:0] e_in1, logic [7:0] e_in2,
                              logic [1:0] e_op, logic e_sub);
    vec_t v;
    v.rst = rst; v.wen = wen; v.wa = wa; v.wd = wd; v.iv = iv; v.rs = rs; v.rt = rt;
    v.isel = isel; v.im = im; v.op = op; v.si = si; v.st = st; v.fl = fl;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_in1 = e_in1; v.e_in2 = e_in2;
    v.e_op = e_op; v.e_sub = e_sub;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s [vec %0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; wr_en = v.wen; wr_addr = v.wa; wr_data = v.wd;
    in_valid = v.iv; rs_addr = v.rs; rt_addr = v.rt; imm_sel = v.isel;
    imm = v.im; op_in = v.op; sub_in = v.si; stall = v.st; flush = v.fl;
  endtask

  task automatic check_outs(input int idx, input logic ov, input logic [7:0] a,
                            input logic [7:0] b, input logic [1:0] op, input logic s);
    check("out_valid", idx, 32'(out_valid), 32'(ov));
    check("in1",       idx, 32'(in1),       32'(a));
    check("in2",       idx, 32'(in2),       32'(b));
    check("alu_op",    idx, 32'(alu_op),    32'(op));
    check("sub",       idx, 32'(sub),       32'(s));
  endtask

  initial begin
    // Hand sequence: reset held two cycles with a live instruction and a write offered
    drive(mk(1, 1, 3, 8'h77, 1, 3, 3, 0, 8'h00, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    repeat (2) begin
      @(posedge clk); #1;
      check_outs(-1, 0, 8'h00, 8'h00, 2'b00, 0);
    end

    //        rst wen wa wd    iv rs rt is imm    op    si st fl | rdy ov in1    in2    op    sub
    // 0: reset edge discards the R3 write and the capture
    vecs.push_back(mk(1, 1, 3, 8'h77, 1, 3, 3, 0, 8'h00, 2'b00, 1, 0, 0, 1, 0, 8'h00, 8'h00, 2'b00, 0));
    // 1: R3 reads back zero after reset
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 3, 0, 0, 8'h00, 2'b01, 1, 0, 0, 1, 1, 8'h00, 8'h00, 2'b01, 0));
    // 2-3: write R1, R2; bubbles hold data fields
    vecs.push_back(mk(0, 1, 1, 8'h12, 0, 0, 0, 0, 8'h00, 2'b00, 0, 0, 0, 1, 0, 8'h00, 8'h00, 2'b01, 0));
    vecs.push_back(mk(0, 1, 2, 8'h34, 0, 0, 0, 0, 8'h00, 2'b00, 0, 0, 0, 1, 0, 8'h00, 8'h00, 2'b01, 0));
    // 4: rs=1 rt=2 add/sub
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 2, 0, 8'h00, 2'b00, 1, 0, 0, 1, 1, 8'h12, 8'h34, 2'b00, 1));
    // 5: double bypass rs=rt=wr=5
    vecs.push_back(mk(0, 1, 5, 8'hA5, 1, 5, 5, 0, 8'h00, 2'b01, 1, 0, 0, 1, 1, 8'hA5, 8'hA5, 2'b01, 0));
    // 6: immediate, xor clears sub
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 7, 1, 8'h0F, 2'b10, 1, 0, 0, 1, 1, 8'h12, 8'h0F, 2'b10, 0));
    // 7: shift
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 2, 1, 0, 8'h00, 2'b11, 0, 0, 0, 1, 1, 8'h34, 8'h12, 2'b11, 0));
    // 8-10: stall three cycles with pending instruction; write R4 during stall
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 5, 2, 0, 8'h00, 2'b00, 1, 1, 0, 0, 1, 8'h34, 8'h12, 2'b11, 0));
    vecs.push_back(mk(0, 1, 4, 8'h44, 1, 5, 2, 0, 8'h00, 2'b00, 1, 1, 0, 0, 1, 8'h34, 8'h12, 2'b11, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 5, 2, 0, 8'h00, 2'b00, 1, 1, 0, 0, 1, 8'h34, 8'h12, 2'b11, 0));
    // 11: release stall, pending instruction captured
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 5, 2, 0, 8'h00, 2'b00, 1, 0, 0, 1, 1, 8'hA5, 8'h34, 2'b00, 1));
    // 12: write made during stall is visible
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 4, 4, 0, 8'h00, 2'b00, 0, 0, 0, 1, 1, 8'h44, 8'h44, 2'b00, 0));
    // 13: flush beats stall and capture; write-back to R6 still lands
    vecs.push_back(mk(0, 1, 6, 8'h66, 1, 1, 2, 0, 8'h00, 2'b01, 0, 1, 1, 0, 0, 8'h00, 8'h00, 2'b00, 0));
    // 14: R6 readback
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 6, 6, 0, 8'h00, 2'b10, 0, 0, 0, 1, 1, 8'h66, 8'h66, 2'b10, 0));
    // 15: flush with in_ready=1 drops the offered instruction
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 2, 0, 8'h00, 2'b11, 0, 0, 1, 1, 0, 8'h00, 8'h00, 2'b00, 0));
    // 16: bubble
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1, 2, 0, 8'h00, 2'b11, 1, 0, 0, 1, 0, 8'h00, 8'h00, 2'b00, 0));
    // 17: bypass on rs only
    vecs.push_back(mk(0, 1, 7, 8'h5A, 1, 7, 3, 0, 8'h00, 2'b00, 1, 0, 0, 1, 1, 8'h5A, 8'h00, 2'b00, 1));
    // 18: bypass on rt only
    vecs.push_back(mk(0, 1, 3, 8'hC3, 1, 1, 3, 0, 8'h00, 2'b11, 1, 0, 0, 1, 1, 8'h12, 8'hC3, 2'b11, 0));
    // 19: R0 is an ordinary register; imm with bit 7 set passes unchanged
    vecs.push_back(mk(0, 1, 0, 8'h99, 1, 0, 3, 1, 8'h80, 2'b00, 0, 0, 0, 1, 1, 8'h99, 8'h80, 2'b00, 0));
    // 20: stall with no instruction keeps out_valid=1
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2'b00, 0, 1, 0, 0, 1, 8'h99, 8'h80, 2'b00, 0));
    // 21: bubble clears valid, data held
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2'b01, 1, 0, 0, 1, 0, 8'h99, 8'h80, 2'b00, 0));
    // 22: reset beats stall
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 1, 2, 0, 8'h00, 2'b01, 1, 1, 0, 0, 0, 8'h00, 8'h00, 2'b00, 0));
    // 23: registers cleared by that reset
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 7, 0, 8'h00, 2'b00, 1, 0, 0, 1, 1, 8'h00, 8'h00, 2'b00, 1));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check("in_ready", i, 32'(in_ready), 32'(vecs[i].e_rdy));
      @(posedge clk); #1;
      check_outs(i, vecs[i].e_ov, vecs[i].e_in1, vecs[i].e_in2, vecs[i].e_op, vecs[i].e_sub);
    end

    // Hand sequence: in_ready ignores in_valid, follows stall combinationally
    @(negedge clk);
    drive(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    #1 check("in_ready_nv_stall", 100, 32'(in_ready), 32'(1'b0));
    stall = 1'b0;
    #1 check("in_ready_nv_go", 101, 32'(in_ready), 32'(1'b1));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
